// File: rtl/display_arbiter.sv
// Two-requester display arbiter: time-sliced ownership of a 4-digit hex display
// with round-robin tie-break, early release and direct owner-to-owner handover.
module display_arbiter #(
    parameter int unsigned DWELL = 50000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [1:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    output logic [1:0]  grant,
    output logic [15:0] disp_word,
    output logic        disp_valid
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

    localparam logic [25:0] RELOAD = 26'(DWELL - 1);

    state_e      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [25:0] cnt_q, cnt_d;
    logic [1:0]  grant_q;
    logic [15:0] word_q;
    logic        valid_q;

    logic   owner;
    logic   own_req, oth_req;
    state_e oth_state;

    assign owner     = (state_q == OWN1);
    assign own_req   = req[owner];
    assign oth_req   = req[~owner];
    assign oth_state = owner ? OWN0 : OWN1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = (cnt_q == 26'd0) ? 26'd0 : cnt_q - 26'd1;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    cnt_d = RELOAD;
                    if (req == 2'b11) state_d = ptr_q ? OWN1 : OWN0;
                    else              state_d = req[1] ? OWN1 : OWN0;
                end
            end
            OWN0, OWN1: begin
                // Expiry takes precedence over early release in the same cycle.
                if (cnt_q == 26'd0) begin
                    if (oth_req) begin
                        state_d = oth_state;
                        ptr_d   = ~owner;
                        cnt_d   = RELOAD;
                    end else if (own_req) begin
                        cnt_d   = RELOAD;
                    end else begin
                        state_d = IDLE;
                        ptr_d   = ~owner;
                    end
                end else if (!own_req) begin
                    ptr_d   = ~owner;
                    state_d = oth_req ? oth_state : IDLE;
                    if (oth_req) cnt_d = RELOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= 26'd0;
            grant_q <= 2'b00;
            word_q  <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= {state_d == OWN1, state_d == OWN0};
            valid_q <= (state_d != IDLE);
            // Word follows the current owner's data one cycle behind; holds in IDLE.
            if (state_q == OWN0)      word_q <= data0;
            else if (state_q == OWN1) word_q <= data1;
        end
    end

    assign grant      = grant_q;
    assign disp_word  = word_q;
    assign disp_valid = valid_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter (DWELL=4): vector table with scoreboard queue plus
// hand-written asynchronous-reset sequence.
module tb_display_arbiter;

    typedef struct {
        bit          rst;
        logic [1:0]  req;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  eg;
        logic [15:0] ew;
        logic        ev;
    } vec_t;

    typedef struct {
        int          idx;
        logic [1:0]  eg;
        logic [15:0] ew;
        logic        ev;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [15:0] data0 = 16'h0000;
    logic [15:0] data1 = 16'h0000;
    logic [1:0]  grant;
    logic [15:0] disp_word;
    logic        disp_valid;

    int checks = 0;
    int failures = 0;
    vec_t tbl[$];
    exp_t sb[$];

    display_arbiter #(.DWELL(4)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .data0(data0), .data1(data1),
        .grant(grant), .disp_word(disp_word), .disp_valid(disp_valid)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h expected=%h", name, idx, got, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_grant"}, 0, 32'(grant), 32'd0);
        chk({name, "_word"},  0, 32'(disp_word), 32'd0);
        chk({name, "_valid"}, 0, 32'(disp_valid), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        req     = 2'b00;
        #1 chk_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic step(input int idx, input logic [1:0] r, input logic [15:0] d0, input logic [15:0] d1,
                        input logic [1:0] eg, input logic [15:0] ew, input logic ev);
        exp_t e;
        exp_t got;
        @(negedge clock);
        req = r; data0 = d0; data1 = d1;
        e.idx = idx; e.eg = eg; e.ew = ew; e.ev = ev;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_empty[%0d] got=0 expected=1", idx);
        end else begin
            got = sb.pop_front();
            chk("grant", got.idx, 32'(grant), 32'(got.eg));
            chk("disp_word", got.idx, 32'(disp_word), 32'(got.ew));
            chk("disp_valid", got.idx, 32'(disp_valid), 32'(got.ev));
        end
    endtask

    function automatic vec_t v(input bit rst, input logic [1:0] r, input logic [15:0] d0, input logic [15:0] d1,
                               input logic [1:0] eg, input logic [15:0] ew, input logic ev);
        vec_t t;
        t.rst = rst; t.req = r; t.d0 = d0; t.d1 = d1; t.eg = eg; t.ew = ew; t.ev = ev;
        return t;
    endfunction

    initial begin
        // Single requester, reload, data change, early release, pointer-driven tie-break.
        tbl.push_back(v(1, 2'b01, 16'h1234, 16'h5678, 2'b01, 16'h0000, 1));
        tbl.push_back(v(0, 2'b01, 16'h1234, 16'h5678, 2'b01, 16'h1234, 1));
        tbl.push_back(v(0, 2'b01, 16'h1234, 16'h5678, 2'b01, 16'h1234, 1));
        tbl.push_back(v(0, 2'b01, 16'h1234, 16'h5678, 2'b01, 16'h1234, 1));
        tbl.push_back(v(0, 2'b01, 16'h1234, 16'h5678, 2'b01, 16'h1234, 1));
        tbl.push_back(v(0, 2'b01, 16'hBEEF, 16'h5678, 2'b01, 16'hBEEF, 1));
        tbl.push_back(v(0, 2'b00, 16'hBEEF, 16'h5678, 2'b00, 16'hBEEF, 0));
        tbl.push_back(v(0, 2'b00, 16'h1234, 16'h5678, 2'b00, 16'hBEEF, 0));
        tbl.push_back(v(0, 2'b11, 16'h1234, 16'h5678, 2'b10, 16'hBEEF, 1));
        tbl.push_back(v(0, 2'b11, 16'h1234, 16'h5678, 2'b10, 16'h5678, 1));
        tbl.push_back(v(0, 2'b11, 16'h1234, 16'h5678, 2'b10, 16'h5678, 1));
        tbl.push_back(v(0, 2'b11, 16'h1234, 16'h5678, 2'b10, 16'h5678, 1));
        tbl.push_back(v(0, 2'b11, 16'h1234, 16'h5678, 2'b01, 16'h5678, 1));
        tbl.push_back(v(0, 2'b11, 16'h1234, 16'h5678, 2'b01, 16'h1234, 1));
        // Simultaneous start: alternating 4-cycle slices with no gap.
        tbl.push_back(v(1, 2'b11, 16'h1234, 16'h5678, 2'b01, 16'h0000, 1));
        tbl.push_back(v(0, 2'b11, 16'h1234, 16'h5678, 2'b01, 16'h1234, 1));
        tbl.push_back(v(0, 2'b11, 16'h1234, 16'h5678, 2'b01, 16'h1234, 1));
        tbl.push_back(v(0, 2'b11, 16'h1234, 16'h5678, 2'b01, 16'h1234, 1));
        tbl.push_back(v(0, 2'b11, 16'h1234, 16'h5678, 2'b10, 16'h1234, 1));
        tbl.push_back(v(0, 2'b11, 16'h1234, 16'h5678, 2'b10, 16'h5678, 1));
        tbl.push_back(v(0, 2'b11, 16'h1234, 16'h5678, 2'b10, 16'h5678, 1));
        tbl.push_back(v(0, 2'b11, 16'h1234, 16'h5678, 2'b10, 16'h5678, 1));
        tbl.push_back(v(0, 2'b11, 16'h1234, 16'h5678, 2'b01, 16'h5678, 1));
        tbl.push_back(v(0, 2'b11, 16'h1234, 16'h5678, 2'b01, 16'h1234, 1));
        // No pre-emption, then owner drops exactly at expiry while the other requests.
        tbl.push_back(v(1, 2'b01, 16'h1234, 16'h5678, 2'b01, 16'h0000, 1));
        tbl.push_back(v(0, 2'b11, 16'h1234, 16'h5678, 2'b01, 16'h1234, 1));
        tbl.push_back(v(0, 2'b11, 16'h1234, 16'h5678, 2'b01, 16'h1234, 1));
        tbl.push_back(v(0, 2'b11, 16'h1234, 16'h5678, 2'b01, 16'h1234, 1));
        tbl.push_back(v(0, 2'b10, 16'h1234, 16'h5678, 2'b10, 16'h1234, 1));
        tbl.push_back(v(0, 2'b10, 16'h1234, 16'h5678, 2'b10, 16'h5678, 1));
        // Early release with the other requester waiting: direct handover mid-slice.
        tbl.push_back(v(1, 2'b01, 16'hA0A0, 16'h0B0B, 2'b01, 16'h0000, 1));
        tbl.push_back(v(0, 2'b01, 16'hA0A0, 16'h0B0B, 2'b01, 16'hA0A0, 1));
        tbl.push_back(v(0, 2'b11, 16'hA0A0, 16'h0B0B, 2'b01, 16'hA0A0, 1));
        tbl.push_back(v(0, 2'b10, 16'hA0A0, 16'h0B0B, 2'b10, 16'hA0A0, 1));
        tbl.push_back(v(0, 2'b10, 16'hA0A0, 16'h0B0B, 2'b10, 16'h0B0B, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            step(i, tbl[i].req, tbl[i].d0, tbl[i].d1, tbl[i].eg, tbl[i].ew, tbl[i].ev);
        end

        // Mid-slice asynchronous reset from OWN1, then restart with pointer 0.
        do_reset();
        step(100, 2'b10, 16'h1234, 16'hABCD, 2'b10, 16'h0000, 1);
        step(101, 2'b10, 16'h1234, 16'hABCD, 2'b10, 16'hABCD, 1);
        #2 reset_n = 1'b0;
        #1 chk_zero("async_reset");
        @(negedge clock);
        reset_n = 1'b1;
        req     = 2'b00;
        #1 chk_zero("post_release");
        step(102, 2'b11, 16'h1234, 16'hABCD, 2'b01, 16'h0000, 1);
        step(103, 2'b11, 16'h1234, 16'hABCD, 2'b01, 16'h1234, 1);

        chk("scoreboard_drained", 0, 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 The block SHALL have parameter DWELL, default 50000000, giving the time-slice length in clock cycles; legal range 2..2^26-1.
REQ-002 clock  in  1  sole clock; all state changes on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 req  in  2  per-requester display-ownership request; bit i belongs to requester i; level-sensitive.
REQ-005 data0  in  16  requester 0 hex word, nibble [15:12] for the leftmost digit, [3:0] for the rightmost.
REQ-006 data1  in  16  requester 1 hex word, same nibble layout.
REQ-007 grant  out  2  one-hot or zero; bit i high while requester i owns the display.
REQ-008 disp_word  out  16  word forwarded to the 4-digit multiplexer.
REQ-009 disp_valid  out  1  high while disp_word carries an owner's data.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, OWN0 and OWN1. grant SHALL be a registered decode of the state: 00, 01 or 10.
REQ-011 A 1-bit priority pointer SHALL name the preferred requester. It SHALL be set to the non-owner on every exit from an OWN state.
REQ-012 From IDLE, if exactly one req bit is high, the FSM SHALL move to that requester's OWN state on the next edge.
REQ-013 From IDLE, if both req bits are high, the FSM SHALL move to the OWN state named by the pointer.
REQ-014 Grant latency SHALL be one cycle: req sampled high in IDLE at edge k gives grant high after edge k.
REQ-015 On entry to an OWN state, a 26-bit dwell counter SHALL load DWELL-1. It SHALL decrement by 1 each cycle in the OWN state and SHALL saturate at 0, never wrapping.
REQ-016 Slice expiry SHALL be the counter reaching 0. On expiry:
  - other requester's req high: switch directly to its OWN state, with no IDLE cycle between.
  - otherwise, owner's req high: stay in the OWN state and reload DWELL-1.
  - otherwise: go to IDLE.
REQ-017 Early release: if the owner's req is low before expiry, the FSM SHALL leave on the next edge. It SHALL go to the other OWN state if the other req is high, else to IDLE.
REQ-018 A non-owner's req SHALL NOT pre-empt the owner before expiry.
REQ-019 In either OWN state, disp_word SHALL register the owner's data input every cycle, so data changes appear one cycle later. disp_valid SHALL be 1 in those cycles.
REQ-020 In IDLE, disp_word SHALL hold its last value and disp_valid SHALL be 0.
REQ-021 On a direct OWN0<->OWN1 switch, disp_word SHALL carry the new owner's data in the first cycle after the switch edge. disp_valid SHALL stay high with no gap.
REQ-022 An owner's req dropping in the same cycle as expiry SHALL follow the REQ-016 expiry rules. The early-release rule SHALL NOT apply in that cycle.

Reset
REQ-023 While reset_n is low, the block SHALL immediately and asynchronously force:
  - state = IDLE
  - grant = 00
  - disp_word = 16'h0000
  - disp_valid = 0
  - pointer = 0
  - dwell counter = 0
REQ-024 Reset asserted mid-slice SHALL abandon the slice. After release, arbitration SHALL restart from IDLE with pointer 0.
REQ-025 Release of reset_n SHALL take effect at the first rising clock edge after release. No output SHALL change before that edge.

Verification (DWELL=4)
REQ-026 Single requester: req=01, data0=16'h1234 -> grant=01 after 1 edge; disp_word=16'h1234 and disp_valid=1 after 2 edges; grant stays 01 across reloads while req holds.
REQ-027 Simultaneous start: reset, then req=11 -> grant 01 for 4 cycles, then 10 for 4 cycles, then 01; no cycle with grant=00 or disp_valid=0.
REQ-028 Early release: req=01 granted, then req0 drops after 2 cycles -> grant=00 and disp_valid=0 next edge; disp_word holds its last value; pointer=1.
REQ-029 No pre-emption: OWN0 active, req1 rises at counter=3 -> grant stays 01 until the counter reaches 0, then becomes 10 on the next edge; disp_word becomes data1 one cycle later.
REQ-030 Mid-slice reset: OWN1 with disp_word=16'hABCD, pulse reset_n low mid-cycle -> outputs go to 0 immediately without a clock edge; with req=11 after release -> grant=01 first.
REQ-031 Expiry with simultaneous drop: OWN0, req0 drops exactly at counter=0 while req1=1 -> direct switch to OWN1; disp_valid stays continuously high.
